// File: rtl/seq_shift_add_mult_if.sv
// Handshake/bus interface for seq_shift_add_mult.
// The master side issues start with operands A/B; the slave side (the
// multiplier) returns busy, the done pulse and the product Z.
interface seq_shift_add_mult_if #(
    parameter int N = 4
);
    logic             start;
    logic [N-1:0]     A;
    logic [N-1:0]     B;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   Z;

    modport master (
        output start, A, B,
        input  busy, done, Z
    );

    modport slave (
        input  start, A, B,
        output busy, done, Z
    );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier, N x N -> 2N bits.
// One (N+1)-bit adder is reused over N RUN cycles. A start seen in IDLE or
// in the DONE cycle is accepted, so operations can run back-to-back.
// Latency: start accepted at edge k -> done high in the cycle after edge k+N+1.
// Optional macro SEQ_MULT_SIGNED_EN: two's-complement operands and product
// (magnitudes run through the unsigned core, sign applied on the Z write).
module seq_shift_add_mult #(
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               rst,
    seq_shift_add_mult_if.slave bus
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * N;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    mcand_q, mcand_d;
    logic [N-1:0]    mult_q,  mult_d;
    logic [N:0]      acc_q,   acc_d;    // acc_hi: bit N holds the adder carry
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [PW-1:0]   z_q,     z_d;
    logic            done_q;
`ifdef SEQ_MULT_SIGNED_EN
    logic            sign_q,  sign_d;
`endif

    // One iteration of the datapath, shared by the RUN state.
    logic [N:0]      sum;
    logic [N:0]      step_acc;
    logic [N-1:0]    step_mult;
    logic [PW-1:0]   product;
    logic            accept;

    // Combinational datapath step: conditional add, then shift {acc_hi, mult} right.
    always_comb begin
        sum       = acc_q + (mult_q[0] ? {1'b0, mcand_q} : '0);
        step_acc  = {1'b0, sum[N:1]};
        step_mult = {sum[0], mult_q[N-1:1]};
        product   = {sum[N:1], step_mult};
        accept    = bus.start && ((state_q == IDLE) || (state_q == DONE));
    end

    // Next-state and datapath-load logic.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the
        // case below can leave one unassigned and infer a latch.
        state_d = state_q;
        mcand_d = mcand_q;
        mult_d  = mult_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
`ifdef SEQ_MULT_SIGNED_EN
        sign_d  = sign_q;
`endif

        unique case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            RUN: begin
                acc_d  = step_acc;
                mult_d = step_mult;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    cnt_d   = '0;
`ifdef SEQ_MULT_SIGNED_EN
                    z_d     = sign_q ? PW'(-product) : product;
`else
                    z_d     = product;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Acceptance overrides the IDLE/DONE defaults; RUN ignores start.
        if (accept) begin
            state_d = RUN;
            acc_d   = '0;
            cnt_d   = '0;
`ifdef SEQ_MULT_SIGNED_EN
            mcand_d = bus.A[N-1] ? N'(-bus.A) : bus.A;
            mult_d  = bus.B[N-1] ? N'(-bus.B) : bus.B;
            sign_d  = bus.A[N-1] ^ bus.B[N-1];
`else
            mcand_d = bus.A;
            mult_d  = bus.B;
`endif
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value, independent of block order.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: operands, accumulator, counter and result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q <= '0;
            mult_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            mcand_q <= mcand_d;
            mult_q  <= mult_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q  <= sign_d;
`endif
        end
    end

    // done is registered off the DONE state: a clean one-cycle pulse that
    // arrives after Z has already been written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == DONE);
        end
    end

    assign bus.busy = (state_q == RUN) || (state_q == DONE);
    assign bus.done = done_q;
    assign bus.Z    = z_q;

endmodule
